// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory access path.
//   - MEM_* : bit positions of the decoder's one-hot mem_src vector.
//   - state_t : mem_access_unit FSM state encoding.
//   - op_t : compact operation code derived from mem_src (lowest set bit wins).
//   - decode_op / is_load / is_store : helpers used by the unit and its datapath.
package mem_access_unit_pkg;

  localparam int MEM_SRC_W = 12;

  localparam int MEM_LW  = 0;
  localparam int MEM_LB  = 1;
  localparam int MEM_LBU = 2;
  localparam int MEM_LH  = 3;
  localparam int MEM_LHU = 4;
  localparam int MEM_LWL = 5;
  localparam int MEM_LWR = 6;
  localparam int MEM_SW  = 7;
  localparam int MEM_SB  = 8;
  localparam int MEM_SH  = 9;
  localparam int MEM_SWL = 10;
  localparam int MEM_SWR = 11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Op codes share their numeric value with the mem_src bit index.
  typedef enum logic [3:0] {
    OP_LW   = 4'd0,
    OP_LB   = 4'd1,
    OP_LBU  = 4'd2,
    OP_LH   = 4'd3,
    OP_LHU  = 4'd4,
    OP_LWL  = 4'd5,
    OP_LWR  = 4'd6,
    OP_SW   = 4'd7,
    OP_SB   = 4'd8,
    OP_SH   = 4'd9,
    OP_SWL  = 4'd10,
    OP_SWR  = 4'd11,
    OP_NONE = 4'd15
  } op_t;

  // Priority-encode mem_src. Scanning from the top down lets the lowest
  // set bit overwrite any higher one, so an illegal multi-hot input still
  // resolves deterministically.
  function automatic op_t decode_op(input logic [MEM_SRC_W-1:0] src);
    op_t op;
    op = OP_NONE;
    for (int i = MEM_SRC_W - 1; i >= 0; i--) begin
      if (src[i]) op = op_t'(i[3:0]);
    end
    return op;
  endfunction

  function automatic logic is_store(input op_t op);
    return op inside {OP_SW, OP_SB, OP_SH, OP_SWL, OP_SWR};
  endfunction

  function automatic logic is_load(input op_t op);
    return op inside {OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LWL, OP_LWR};
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane datapath for mem_access_unit.
// Ports:
//   op        : decoded memory operation
//   byte_off  : addr[1:0] of the access
//   rt_data   : store source / old rt value for LWL/LWR merge
//   rdata     : word returned by the memory bus
//   strb      : byte write strobes (0000 for loads and no-op)
//   wdata     : lane-shifted write data (0 for loads and no-op)
//   load_data : extracted, extended or merged load result (0 for stores)
// Byte ordering is little-endian: byte k lives in bits [8k+7:8k].
module mem_align
  import mem_access_unit_pkg::*;
(
  input  op_t         op,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rt_data,
  input  logic [31:0] rdata,
  output logic [3:0]  strb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  // lo_sh = 8*a, hi_sh = 8*(3-a); for a 2-bit a, 3-a is simply ~a.
  logic [4:0]  lo_sh;
  logic [4:0]  hi_sh;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign lo_sh   = {byte_off, 3'b000};
  assign hi_sh   = {~byte_off, 3'b000};
  assign rd_byte = rdata[lo_sh +: 8];
  assign rd_half = byte_off[1] ? rdata[31:16] : rdata[15:0];

  // Store path.
  always_comb begin
    strb  = 4'b0000;
    wdata = 32'h0;
    case (op)
      OP_SW: begin
        strb  = 4'b1111;
        wdata = rt_data;
      end
      OP_SB: begin
        strb  = 4'b0001 << byte_off;
        wdata = {4{rt_data[7:0]}};
      end
      OP_SH: begin
        strb  = byte_off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{rt_data[15:0]}};
      end
      OP_SWL: begin
        // Writes the top (a+1) bytes of rt into lanes 0..a.
        strb  = 4'b1111 >> ~byte_off;
        wdata = rt_data >> hi_sh;
      end
      OP_SWR: begin
        // Writes the low (4-a) bytes of rt into lanes a..3.
        strb  = 4'b1111 << byte_off;
        wdata = rt_data << lo_sh;
      end
      default: begin
        strb  = 4'b0000;
        wdata = 32'h0;
      end
    endcase
  end

  // Load path.
  always_comb begin
    load_data = 32'h0;
    case (op)
      OP_LW:  load_data = rdata;
      OP_LB:  load_data = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU: load_data = {24'h0, rd_byte};
      OP_LH:  load_data = {{16{rd_half[15]}}, rd_half};
      OP_LHU: load_data = {16'h0, rd_half};
      OP_LWL: begin
        case (byte_off)
          2'd0:    load_data = {rdata[7:0],  rt_data[23:0]};
          2'd1:    load_data = {rdata[15:0], rt_data[15:0]};
          2'd2:    load_data = {rdata[23:0], rt_data[7:0]};
          default: load_data = rdata;
        endcase
      end
      OP_LWR: begin
        case (byte_off)
          2'd0:    load_data = rdata;
          2'd1:    load_data = {rt_data[31:24], rdata[31:8]};
          2'd2:    load_data = {rt_data[31:16], rdata[31:16]};
          default: load_data = {rt_data[31:8],  rdata[31:24]};
        endcase
      end
      default: load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle data-memory access unit.
// Accepts one load/store per req handshake, drives one word-aligned bus
// request, waits for read data on loads, and pulses done for one cycle.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   req_valid/ready   : request handshake (accepted when both are 1 at a rising edge)
//   mem_src           : one-hot operation select from the decoder
//   addr, rt_data     : effective address, store data / merge source
//   mem_addr/valid/ready/wen/strb/wdata : bus request channel
//   mem_rdata, mem_rdata_valid          : bus read-data return
//   done              : one-cycle completion pulse
//   load_data         : last completed load result, held until the next load completes
//   dbg_state         : current FSM state (state_t encoding)
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; a valid side holds its payload stable until that edge, and ready
// never depends combinationally on the same-cycle valid of the other side.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [MEM_SRC_W-1:0] mem_src,
  input  logic [31:0]          addr,
  input  logic [31:0]          rt_data,
  output logic [31:0]          mem_addr,
  output logic                 mem_valid,
  input  logic                 mem_ready,
  output logic                 mem_wen,
  output logic [3:0]           mem_strb,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_rdata_valid,
  output logic                 done,
  output logic [31:0]          load_data,
  output logic [1:0]           dbg_state
);

  state_t      state_q;
  state_t      state_d;
  op_t         op_q;
  op_t         op_in;
  logic [31:0] addr_q;
  logic [31:0] rt_q;
  logic [31:0] load_q;
  logic        accept;
  logic        capture_load;

  logic [3:0]  align_strb;
  logic [31:0] align_wdata;
  logic [31:0] align_load;

  assign op_in = decode_op(mem_src);

  // Next state and handshake outputs.
  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    mem_valid    = 1'b0;
    done         = 1'b0;
    accept       = 1'b0;
    capture_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          // An empty mem_src completes without touching the bus.
          state_d = (op_in == OP_NONE) ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        mem_valid = 1'b1;
        if (mem_ready) begin
          state_d = is_store(op_q) ? ST_DONE : ST_WAIT_RD;
        end
      end
      ST_WAIT_RD: begin
        if (mem_rdata_valid) begin
          capture_load = 1'b1;
          state_d      = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request capture: everything the bus sees is derived from these
  // registers, so bus outputs cannot move while mem_valid waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= OP_NONE;
      addr_q <= 32'h0;
      rt_q   <= 32'h0;
    end else if (accept) begin
      op_q   <= op_in;
      addr_q <= addr;
      rt_q   <= rt_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q <= 32'h0;
    end else if (capture_load) begin
      load_q <= align_load;
    end
  end

  mem_align u_align (
    .op        (op_q),
    .byte_off  (addr_q[1:0]),
    .rt_data   (rt_q),
    .rdata     (mem_rdata),
    .strb      (align_strb),
    .wdata     (align_wdata),
    .load_data (align_load)
  );

  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wen   = is_store(op_q);
  assign mem_strb  = align_strb;
  assign mem_wdata = align_wdata;
  assign load_data = load_q;
  assign dbg_state = state_q;

endmodule
